// File: rtl/if_id_stage.sv
// IF stage PC register plus IF/ID pipeline register, with a stall watchdog that
// counts consecutive and total hazard stalls and raises a sticky timeout flag.
module if_id_stage #(
    parameter logic [63:0] PC_RESET  = 64'h0,
    parameter int          MAX_STALL = 4,
    parameter logic [31:0] NOP       = 32'h00000013
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        enable,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] instruction_IF,
    output logic [63:0] pc_IF,
    output logic [63:0] pc_ID,
    output logic [31:0] instruction_ID,
    output logic        valid_ID,
    output logic        stall_timeout,
    output logic [15:0] stall_cycles
);
    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_STALL);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {RUN, STALL, TIMEOUT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pc_q, pc_d, pc_id_q, pc_id_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   sc_q, sc_d;
    logic          is_stall;

    assign is_stall = enable & ~PCWrite & ~IF_ID_Write & ~branch_taken;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        pc_id_d   = pc_id_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        sc_d      = sc_q;
        if (enable) begin
            if (branch_taken)  pc_d = branch_target;
            else if (PCWrite)  pc_d = pc_q + 64'd4;

            // A redirect squashes the wrong-path word but keeps the old pc_ID.
            if (branch_taken) begin
                instr_d = NOP;
                valid_d = 1'b0;
            end else if (IF_ID_Write) begin
                instr_d = instruction_IF;
                pc_id_d = pc_q;
                valid_d = 1'b1;
            end

            if (is_stall && sc_q != 16'hFFFF) sc_d = sc_q + 16'd1;

            case (state_q)
                RUN: begin
                    if (is_stall) begin
                        cnt_d = ONE_C;
                        if (ONE_C >= MAX_C) begin
                            state_d   = TIMEOUT;
                            timeout_d = 1'b1;
                        end else begin
                            state_d = STALL;
                        end
                    end
                end
                STALL: begin
                    if (is_stall) begin
                        if (cnt_q + ONE_C >= MAX_C) begin
                            cnt_d     = MAX_C;
                            state_d   = TIMEOUT;
                            timeout_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + ONE_C;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                TIMEOUT: timeout_d = 1'b1;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            pc_q      <= PC_RESET;
            pc_id_q   <= PC_RESET;
            instr_q   <= NOP;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            sc_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            pc_id_q   <= pc_id_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            sc_q      <= sc_d;
        end
    end

    assign pc_IF          = pc_q;
    assign pc_ID          = pc_id_q;
    assign instruction_ID = instr_q;
    assign valid_ID       = valid_q;
    assign stall_timeout  = timeout_q;
    assign stall_cycles   = sc_q;
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter: PC_RESET, default 64'h0, PC value loaded on reset.
REQ-002 Parameter: MAX_STALL, default 4, consecutive-stall-cycle count that raises the timeout flag.
REQ-003 Parameter: NOP, default 32'h00000013, instruction (addi x0,x0,0) inserted on flush/reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 arst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  global advance; 0 freezes every register, counter and FSM state.
REQ-007 PCWrite  in  1  hazard-unit stall response; 0 holds the PC.
REQ-008 IF_ID_Write  in  1  hazard-unit stall response; 0 holds the IF/ID register.
REQ-009 branch_taken  in  1  redirect request resolved in EXE.
REQ-010 branch_target  in  64  redirect PC.
REQ-011 instruction_IF  in  32  instruction-memory data for the current pc_IF, same cycle.
REQ-012 pc_IF  out  64  current fetch PC, drives the instruction-memory address.
REQ-013 pc_ID  out  64  PC of the instruction held in IF/ID.
REQ-014 instruction_ID  out  32  instruction held in IF/ID.
REQ-015 valid_ID  out  1  IF/ID holds a real fetched instruction.
REQ-016 stall_timeout  out  1  sticky flag: MAX_STALL consecutive stall cycles seen.
REQ-017 stall_cycles  out  16  saturating count of all stall cycles since reset.

Function
REQ-018 All state updates occur on the rising edge of clk, only when enable=1.
REQ-019 A stall cycle is defined as enable=1, PCWrite=0, IF_ID_Write=0 and branch_taken=0.
REQ-020 PC update priority: branch_taken=1 loads branch_target; otherwise PCWrite=1 loads pc_IF+4 (64-bit wrap-around, carry discarded); otherwise pc_IF holds.
REQ-021 branch_taken overrides PCWrite=0 and IF_ID_Write=0 in the same cycle.
REQ-022 IF/ID priority: branch_taken=1 loads instruction_ID=NOP, valid_ID=0, pc_ID unchanged; otherwise IF_ID_Write=1 loads instruction_IF, pc_IF and valid_ID=1; otherwise all three hold.
REQ-023 PCWrite=0 with IF_ID_Write=1 re-captures the same fetch word on every such cycle; PCWrite=1 with IF_ID_Write=0 advances the PC and drops the fetched word. Both cases are legal and are not counted as stalls.
REQ-024 FSM states: RUN, STALL, TIMEOUT.
REQ-025 RUN -> STALL on a stall cycle. The consecutive-stall counter is set to 1.
REQ-026 STALL -> STALL on a further stall cycle. The counter increments.
REQ-027 STALL -> RUN on any non-stall enabled cycle. The counter clears.
REQ-028 STALL -> TIMEOUT on the stall cycle that brings the counter to MAX_STALL. stall_timeout is set on that same edge.
REQ-029 TIMEOUT is absorbing until reset and stall_timeout stays 1; the PC and IF/ID behave normally while in TIMEOUT.
REQ-030 The consecutive-stall counter is ceil(log2(MAX_STALL+1)) bits wide and saturates at MAX_STALL.
REQ-031 stall_cycles increments by 1 on every stall cycle in any FSM state and saturates at 16'hFFFF.
REQ-032 enable=0 cycles are neither stall nor non-stall cycles: the FSM, the counter, stall_cycles, the PC and IF/ID all hold.
REQ-033 Outputs are registered only; there is no combinational path from any input to any output.

Reset
REQ-034 arst_n=0 asynchronously forces: pc_IF=PC_RESET, pc_ID=PC_RESET, instruction_ID=NOP, valid_ID=0, FSM=RUN, consecutive counter=0, stall_timeout=0, stall_cycles=0.
REQ-035 Reset asserted mid-stall or mid-branch discards that operation with no partial update.
REQ-036 After release, the first rising edge with enable=1 performs a normal update.

Verification
REQ-037 Reset release, enable=1, PCWrite=IF_ID_Write=1, 3 edges -> pc_IF=0x0C; instruction_ID=word@0x08; pc_ID=0x08; valid_ID=1.
REQ-038 One stall cycle at pc_IF=0x10 -> pc_IF stays 0x10; IF/ID unchanged; stall_cycles=1; FSM returns to RUN the next normal cycle; stall_timeout=0.
REQ-039 branch_taken=1, branch_target=0x200, with PCWrite=IF_ID_Write=0 -> next edge pc_IF=0x200, instruction_ID=0x00000013, valid_ID=0; stall_cycles not incremented.
REQ-040 Four consecutive stall cycles (MAX_STALL=4) -> stall_timeout=1 on the 4th edge and stays 1 after the stalls end, until arst_n=0.
REQ-041 pc_IF=0xFFFF_FFFF_FFFF_FFFC with PCWrite=1 -> pc_IF=0x0; stall_cycles preloaded to 0xFFFF by stalls plus one more stall -> remains 0xFFFF.
REQ-042 Assert arst_n=0 between clock edges during a stall -> all outputs reach reset values immediately; after release, enable=0 for 2 edges -> all outputs unchanged.
